// File: rtl/water_pump_controller.sv
// Tank pump sequencer: sensor sync/debounce, level indicator, pump FSM.
// Ports: clk, rst_n, enable, sensor_*, fault_clr -> indicator, pump_on,
//        state, fault, fault_code.
module water_pump_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MIN_ON_CYCLES   = 8,
  parameter int unsigned MAX_ON_CYCLES   = 64,
  parameter int unsigned MIN_OFF_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       sensor_empty,
  input  logic       sensor_low,
  input  logic       sensor_medium,
  input  logic       sensor_high,
  input  logic       fault_clr,
  output logic [3:0] indicator,
  output logic       pump_on,
  output logic [1:0] state,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(MAX_ON_CYCLES + 1);
  localparam int OW = $clog2(MIN_OFF_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    REST  = 2'b10,
    FAULT = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    L_EMPTY,
    L_LOW,
    L_MEDIUM,
    L_HIGH
  } level_t;

  logic [3:0]    raw;
  logic [3:0]    s1;
  logic [3:0]    s2;
  logic [3:0]    prev;
  logic [3:0]    deb;
  logic          settled;
  logic [DW-1:0] db_cnt;

  assign raw = {sensor_high, sensor_medium,
                sensor_low, sensor_empty};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= '0;
      s2      <= '0;
      prev    <= '0;
      deb     <= '0;
      settled <= 1'b0;
      db_cnt  <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      prev <= s2;
      if (s2 != prev) begin
        db_cnt <= '0;
      end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        deb     <= s2;
        settled <= 1'b1;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  logic   valid;
  level_t level;

  assign valid = $onehot(deb);

  always_comb begin
    level = L_EMPTY;
    if (valid) begin
      unique case (1'b1)
        deb[0]:  level = L_EMPTY;
        deb[1]:  level = L_LOW;
        deb[2]:  level = L_MEDIUM;
        deb[3]:  level = L_HIGH;
        default: level = L_EMPTY;
      endcase
    end
  end

  state_t        state_q;
  state_t        state_d;
  logic [1:0]    code_q;
  logic [1:0]    code_d;
  logic [RW-1:0] run_cnt;
  logic [OW-1:0] off_cnt;
  logic          run_min;
  logic          run_max;
  logic          off_done;
  logic          want_fill;

  assign run_min   = run_cnt >= RW'(MIN_ON_CYCLES - 1);
  assign run_max   = run_cnt == RW'(MAX_ON_CYCLES - 1);
  assign off_done  = off_cnt == OW'(MIN_OFF_CYCLES - 1);
  assign want_fill = (level == L_EMPTY) ||
                     (level == L_LOW);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    if (settled) begin
      unique case (state_q)
        IDLE: begin
          if (!valid) begin
            state_d = FAULT;
            code_d  = 2'b01;
          end else if (enable && want_fill) begin
            state_d = RUN;
          end
        end
        RUN: begin
          // HIGH stop outranks timeout on the last cycle
          if (!valid) begin
            state_d = FAULT;
            code_d  = 2'b01;
          end else if (level == L_HIGH && run_min) begin
            state_d = REST;
          end else if (run_max) begin
            state_d = FAULT;
            code_d  = 2'b10;
          end else if (!enable && run_min) begin
            state_d = REST;
          end
        end
        REST: begin
          if (!valid) begin
            state_d = FAULT;
            code_d  = 2'b01;
          end else if (off_done) begin
            state_d = IDLE;
          end
        end
        FAULT: begin
          if (fault_clr && valid) begin
            state_d = IDLE;
            code_d  = 2'b00;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= 2'b00;
      pump_on <= 1'b0;
      run_cnt <= '0;
      off_cnt <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      pump_on <= (state_d == RUN);
      // counters idle at zero outside their state
      if (state_q != RUN) begin
        run_cnt <= '0;
      end else if (!run_max) begin
        run_cnt <= run_cnt + 1'b1;
      end
      if (state_q != REST) begin
        off_cnt <= '0;
      end else if (!off_done) begin
        off_cnt <= off_cnt + 1'b1;
      end
    end
  end

  assign indicator  = deb;
  assign state      = state_q;
  assign fault      = (state_q == FAULT);
  assign fault_code = code_q;

endmodule

// File: tb/tb_water_pump_controller.sv
// Randomized bench for water_pump_controller against a behavioural model.
// Model: sample-window debounce plus time-in-state pump rules.
module tb_water_pump_controller;

  localparam int DEB    = 4;
  localparam int MINON  = 8;
  localparam int MAXON  = 64;
  localparam int MINOFF = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       s_e, s_l, s_m, s_h;
  logic       fault_clr;
  logic [3:0] indicator;
  logic       pump_on;
  logic [1:0] state;
  logic       fault;
  logic [1:0] fault_code;

  always #5 clk = ~clk;

  water_pump_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .MIN_ON_CYCLES(MINON),
    .MAX_ON_CYCLES(MAXON),
    .MIN_OFF_CYCLES(MINOFF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .sensor_empty(s_e),
    .sensor_low(s_l),
    .sensor_medium(s_m),
    .sensor_high(s_h),
    .fault_clr(fault_clr),
    .indicator(indicator),
    .pump_on(pump_on),
    .state(state),
    .fault(fault),
    .fault_code(fault_code)
  );

  int errors = 0;
  int checks = 0;

  // model: h[k] = raw sampled k edges ago
  logic [3:0] h [0:DEB+2];
  int         since;
  logic [3:0] mdeb;
  bit         msettled;
  int         mst;
  int         mt;
  int         mcode;
  bit         mpump;

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic setraw(input logic [3:0] v);
    {s_h, s_m, s_l, s_e} = v;
  endtask

  task automatic model_reset();
    for (int i = 0; i <= DEB + 2; i++) h[i] = 4'b0000;
    since    = 0;
    mdeb     = 4'b0000;
    msettled = 0;
    mst      = 0;
    mt       = 0;
    mcode    = 0;
    mpump    = 0;
  endtask

  task automatic model_step();
    bit v;
    bit fill;
    bit eq;
    int rc;
    v    = ($countones(mdeb) == 1);
    fill = v && (mdeb == 4'b0001 || mdeb == 4'b0010);
    rc   = (mt < MAXON - 1) ? mt : MAXON - 1;
    if (msettled) begin
      case (mst)
        0: begin
          if (!v) begin mst = 3; mcode = 1; end
          else if (enable && fill) begin mst = 1; mt = 0; end
        end
        1: begin
          if (!v) begin mst = 3; mcode = 1; end
          else if (mdeb == 4'b1000 && rc >= MINON - 1)
            begin mst = 2; mt = 0; end
          else if (rc == MAXON - 1) begin mst = 3; mcode = 2; end
          else if (!enable && rc >= MINON - 1)
            begin mst = 2; mt = 0; end
          else mt++;
        end
        2: begin
          if (!v) begin mst = 3; mcode = 1; end
          else if (mt == MINOFF - 1) mst = 0;
          else mt++;
        end
        default: begin
          if (fault_clr && v) begin mst = 0; mcode = 0; end
        end
      endcase
    end
    mpump = (mst == 1);
    for (int i = DEB + 2; i > 0; i--) h[i] = h[i-1];
    h[0] = {s_h, s_m, s_l, s_e};
    since++;
    if (since >= DEB) begin
      eq = 1;
      for (int i = 3; i <= DEB + 2; i++)
        if (h[i] != h[2]) eq = 0;
      if (eq) begin
        mdeb     = h[2];
        msettled = 1;
      end
    end
  endtask

  task automatic compare();
    chk("indicator", indicator, mdeb);
    chk("pump_on", pump_on, mpump);
    chk("state", state, mst);
    chk("fault", fault, (mst == 3));
    chk("fault_code", fault_code, mcode);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clr_pulse();
    fault_clr = 1'b1;
    cycle();
    fault_clr = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat;
    logic [3:0] old;
    int         dur;
    rst_n     = 1'b0;
    enable    = 1'b1;
    fault_clr = 1'b0;
    setraw(4'b0001);
    model_reset();
    #12;
    compare();
    chk("reset_state", state, 0);
    chk("reset_ind", indicator, 0);
    #10 rst_n = 1'b1;

    // empty held: indicator at edge 7, RUN at edge 8
    cycles(6);
    chk("deb_early", indicator, 0);
    cycle();
    chk("deb_ind", indicator, 4'b0001);
    chk("deb_idle", state, 0);
    cycle();
    chk("start_state", state, 1);
    chk("start_pump", pump_on, 1);
    chk("start_fault", fault, 0);

    // timeout after 64 RUN cycles
    cycles(63);
    chk("pre_timeout", state, 1);
    cycle();
    chk("timeout_state", state, 3);
    chk("timeout_code", fault_code, 2);
    chk("timeout_pump", pump_on, 0);
    clr_pulse();
    chk("clr_idle", state, 0);
    chk("clr_code", fault_code, 0);
    cycle();
    chk("restart", state, 1);

    // HIGH seen exactly when min on-time is met
    setraw(4'b1000);
    cycles(7);
    chk("high_ind", indicator, 4'b1000);
    chk("high_run", state, 1);
    cycle();
    chk("rest_state", state, 2);
    chk("rest_pump", pump_on, 0);
    cycles(7);
    chk("rest_hold", state, 2);
    cycle();
    chk("rest_done", state, 0);

    // multi-hot vector
    setraw(4'b1010);
    cycles(8);
    chk("inv_state", state, 3);
    chk("inv_code", fault_code, 1);
    clr_pulse();
    chk("inv_clr_ign", state, 3);
    setraw(4'b0001);
    cycles(8);
    clr_pulse();
    chk("inv_clr", state, 0);
    cycle();
    chk("inv_restart", state, 1);

    // glitch of high during RUN
    setraw(4'b0010);
    cycles(8);
    chk("glitch_pre", indicator, 4'b0010);
    setraw(4'b0110 | 4'b1000);
    setraw(4'b1010);
    cycles(2);
    setraw(4'b0010);
    cycles(10);
    chk("glitch_ind", indicator, 4'b0010);
    chk("glitch_pump", pump_on, 1);

    // asynchronous reset mid-RUN
    @(posedge clk);
    model_step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pump", pump_on, 0);
    chk("arst_state", state, 0);
    chk("arst_ind", indicator, 0);
    model_reset();
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    cycles(3);
    chk("arst_ind_post", indicator, 0);

    // randomized segments
    for (int seg = 0; seg < 150; seg++) begin
      old = {s_h, s_m, s_l, s_e};
      dur = $urandom_range(1, 40);
      enable = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 9))
        0:       pat = 4'($urandom_range(0, 15));
        1:       pat = 4'b0001 << $urandom_range(0, 3);
        default: pat = 4'b0001 << $urandom_range(0, 3);
      endcase
      if ($urandom_range(0, 9) == 0) begin
        setraw(pat);
        cycles($urandom_range(1, DEB - 1));
        setraw(old);
      end else begin
        setraw(pat);
      end
      for (int c = 0; c < dur; c++) begin
        fault_clr = ($urandom_range(0, 7) == 0);
        cycle();
      end
      fault_clr = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/water_pump_controller.md
Name: water_pump_controller

Overview:
Sequences the tank pump from the four one-hot level sensors (empty/low/medium/high) that feed the water level indicator. Synchronises and debounces the raw sensors, drives the 4-bit level indicator, and runs a pump state machine. The state machine enforces hysteresis (start at empty/low, stop at high), a minimum on-time, a minimum rest time, a dry-run/stuck-sensor timeout, and a latched fault that needs an explicit clear.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles required before the debounced sensor vector updates (>=1)
MIN_ON_CYCLES, 8, minimum cycles spent in RUN before a normal stop (>=1)
MAX_ON_CYCLES, 64, RUN cycles without reaching high before a TIMEOUT fault (> MIN_ON_CYCLES)
MIN_OFF_CYCLES, 8, cycles spent in REST before a restart is allowed (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  level-sensitive permission to start/continue pumping
sensor_empty  input  1  raw asynchronous sensor
sensor_low  input  1  raw asynchronous sensor
sensor_medium  input  1  raw asynchronous sensor
sensor_high  input  1  raw asynchronous sensor
fault_clr  input  1  single-cycle request to leave FAULT
indicator  output  4  debounced sensors {high,medium,low,empty}
pump_on  output  1  registered pump drive
state  output  2  00 IDLE, 01 RUN, 10 REST, 11 FAULT
fault  output  1  high while in FAULT
fault_code  output  2  00 none, 01 INVALID sensor vector, 10 TIMEOUT; held while in FAULT

Behaviour:
- Reset (async, rst_n=0): sync flops=0, debounced vector=0, settled=0, all counters=0, state=IDLE, pump_on=0, fault=0, fault_code=00, indicator=0000. Reset applied during RUN drops pump_on immediately, without waiting for a clock.
- Input path: 2-flop synchroniser per sensor, then a shared stability counter.
  - Counter clears on any cycle where the synchronised vector differs from its previous value.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the vector unchanged, debounced is loaded from the synchronised vector and settled is set to 1. Settled stays 1 until reset.
  - Total latency: a raw change stable from edge N appears on indicator after edge N+2+DEBOUNCE_CYCLES.
  - Glitches shorter than DEBOUNCE_CYCLES synchronised cycles never reach indicator.
- indicator = debounced vector.
- valid = exactly one debounced bit set. 0000 and any multi-hot vector are invalid.
- level: EMPTY, LOW, MEDIUM or HIGH, decoded from the single set bit.
- FSM, evaluated only when settled=1 (while settled=0 the FSM holds IDLE):
  - IDLE:
    - !valid -> FAULT, code 01.
    - enable && level is EMPTY or LOW -> RUN; run_cnt cleared.
    - Otherwise stay in IDLE.
  - RUN: run_cnt increments each cycle, saturating at MAX_ON_CYCLES-1. Exit checks in priority order:
    1. !valid -> FAULT, code 01.
    2. level==HIGH && run_cnt>=MIN_ON_CYCLES-1 -> REST.
    3. run_cnt==MAX_ON_CYCLES-1 -> FAULT, code 10.
    4. !enable && run_cnt>=MIN_ON_CYCLES-1 -> REST.
  - RUN, minimum on-time: HIGH or !enable seen before MIN_ON_CYCLES is satisfied keeps the pump in RUN until the minimum is met, provided the condition still holds at that point.
  - REST: off_cnt counts from 0. When off_cnt==MIN_OFF_CYCLES-1 -> IDLE. !valid -> FAULT, code 01, taking priority over the IDLE exit.
  - FAULT: pump_on=0, fault=1, fault_code held.
    - fault_clr && valid -> IDLE next edge; fault_code returns to 00.
    - fault_clr with !valid is ignored.
    - Sensor changes while in FAULT only update indicator.
- pump_on is a register equal to (next_state==RUN). It rises on the same edge that state becomes RUN and falls on the same edge that state leaves RUN.
- enable deasserted while in IDLE or REST: no start. REST timing continues regardless of enable.
- Simultaneous HIGH and timeout on the final RUN cycle: the HIGH stop wins (REST, no fault).
- Counters are sized to hold their parameter and never wrap.

Test Plan:
- Reset then hold empty=1, enable=1 (defaults) -> indicator=0001 at edge 6 after the raw change; state=RUN and pump_on=1 on the next edge; fault=0.
- From RUN, go low -> medium -> high at 10-cycle spacing -> pump stays on through medium; on the edge after indicator=1000 (run_cnt>=7): state=REST, pump_on=0; IDLE exactly 8 cycles later.
- 2-cycle glitch of sensor_high during RUN -> indicator never shows 1000; pump_on stays 1.
- Hold low=1 with enable=1 for 70 cycles -> FAULT at run_cnt=63, fault_code=10, pump_on=0. fault_clr pulse -> IDLE, then RUN the following edge.
- Drive low=1 and high=1 together -> after debounce: FAULT, fault_code=01. fault_clr while still multi-hot -> stays in FAULT. Restore empty only, then fault_clr -> IDLE.
- Assert rst_n=0 mid-RUN, between clock edges -> pump_on=0 immediately; state=00 and indicator=0000 until the sensors re-debounce after reset is released.
